step_controller: RTL and testbench
==================================

Name: step_controller

Overview:
- Sits directly downstream of the frequency divider: consumes the slow divided square wave C_1Hz, and produces single-cycle step enables in the C_50Mhz domain for the CPU datapath.
- Supports free-run, pause and manual single-step via two raw push-buttons.
- Latches a halt request from the CPU.
- Counts issued steps for the 7-segment/LED debug display.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: C_50Mhz cycles a button must hold a new level before it is accepted (20 ms).
- SYNC_STAGES, 2: flip-flop depth of each input synchronizer (C_1Hz, btn_mode, btn_step, halt). Legal values are ≥2.
- COUNT_W, 16: width of step_count.

Ports:
- C_50Mhz  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- C_1Hz  input  1  divided clock from the divider, treated as asynchronous data and never used as a clock.
- btn_mode  input  1  raw button, active-high; each accepted press toggles run/pause.
- btn_step  input  1  raw button, active-high; each accepted press issues one step while paused.
- halt  input  1  CPU halt request, level.
- step_en  output  1  one-C_50Mhz-cycle step enable pulse.
- running  output  1  high in RUNNING state.
- halted  output  1  high in HALTED state.
- step_count  output  COUNT_W  number of step_en pulses issued.

Behaviour:
- Clock and reset: single clock C_50Mhz; reset rst is asynchronous and active-high.
- Reset values: step_en=0, running=0, halted=0, step_count=0; state=PAUSED; all synchronizers, debounce counters and edge registers cleared.
- Reset mid-operation: aborts any pending pulse or debounce immediately.
- Synchronizers: each input passes through SYNC_STAGES flops.
- Tick detection: tick = synchronized C_1Hz rising edge (current sync=1, previous=0), one cycle wide.
- Debounce:
  - Per button: a counter resets whenever the synchronized level equals the accepted level.
  - Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1, the accepted level flips and the counter clears.
  - press = accepted level 0→1, one cycle wide.
  - Release edges generate nothing.
- FSM states: PAUSED, RUNNING, HALTED.
  - PAUSED: mode_press→RUNNING. step_press→step_en=1 next cycle, stay PAUSED. Ticks ignored.
  - RUNNING: mode_press→PAUSED. tick→step_en=1 next cycle. step_press ignored.
  - HALTED: no step_en. Presses and ticks ignored. Exit only via rst.
  - Any state: synchronized halt=1 → HALTED (highest priority).
- Simultaneous events:
  - halt beats everything; no pulse is issued that cycle.
  - In RUNNING, tick and mode_press in the same cycle: go to PAUSED, no pulse.
  - In PAUSED, step_press and mode_press in the same cycle: go to RUNNING, no pulse.
- Latency:
  - C_1Hz rising at the input pin → step_en high exactly SYNC_STAGES+2 C_50Mhz edges later (sync, edge register, registered output).
  - Accepted press → step_en one cycle after the press strobe.
- step_en: registered output; never high two consecutive cycles, because ticks are ≥2 cycles apart.
- step_count: increments in the same cycle step_en is high (registered alongside it); wraps from all-ones to 0.
- running and halted: registered decodes of the state.

Optional Feature:
- Macro: STEP_COUNT_SAT_EN.
  - Defined: step_count saturates at all-ones. Further step_en pulses are still issued, but the count holds.
  - Undefined: step_count wraps to 0, per Behaviour.

Test Plan:
1. Reset sequencing, with DEBOUNCE_CYCLES=4: assert rst mid-run, with C_1Hz toggling → all outputs 0 asynchronously, state PAUSED. Release → no step_en despite C_1Hz edges.
2. Debounce: btn_step bounces 1,0,1 over 3 cycles, then holds high 4 cycles → exactly one step_en pulse, step_count=1. A 3-cycle glitch alone → no pulse.
3. Run mode: mode press, then C_1Hz period 20 cycles for 5 rising edges → 5 step_en pulses, each SYNC_STAGES+2 cycles after its edge; step_count=5; running=1.
4. Collision: in RUNNING, align mode_press with tick → no pulse, running=0. btn_step press while RUNNING → no pulse.
5. Halt: raise halt during RUNNING → halted=1 after SYNC_STAGES+1 cycles, no further pulses. Mode/step presses and drop of halt → remain HALTED until rst.
6. Wrap/saturate: COUNT_W=4, issue 17 steps → step_count=1 without the macro; =15 with STEP_COUNT_SAT_EN.

Source files
------------

// File: rtl/step_controller.sv
// step_controller: turns synchronized C_1Hz ticks and debounced buttons into single-cycle step enables.
// Optional STEP_COUNT_SAT_EN: step_count saturates at all-ones instead of wrapping.
module step_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2,
  parameter int COUNT_W         = 16
) (
  input  logic               C_50Mhz,
  input  logic               rst,
  input  logic               C_1Hz,
  input  logic               btn_mode,
  input  logic               btn_step,
  input  logic               halt,
  output logic               step_en,
  output logic               running,
  output logic               halted,
  output logic [COUNT_W-1:0] step_count
);
  localparam int DW = DEBOUNCE_CYCLES > 2 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {PAUSED, RUNNING, HALTED} state_t;
  state_t state_q, state_d;
  logic [3:0][SYNC_STAGES-1:0] sync_q;
  logic [3:0] raw, sync;
  logic c1_prev_q, tick_q, step_en_q, running_q, halted_q, en_d;
  logic [1:0] acc_q, press_q, flip;
  logic [1:0][DW-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] count_q, count_inc;
  assign raw = {halt, btn_step, btn_mode, C_1Hz};
  always_comb begin
    sync = '0;
    for (int i = 0; i < 4; i++) sync[i] = sync_q[i][SYNC_STAGES-1];
  end
  // bit 0 of the button vectors is btn_mode, bit 1 is btn_step
  always_comb begin
    flip  = '0;
    cnt_d = '0;
    for (int b = 0; b < 2; b++) begin
      flip[b]  = sync[b+1] != acc_q[b] && cnt_q[b] == DB_MAX;
      cnt_d[b] = (sync[b+1] == acc_q[b] || flip[b]) ? '0 : cnt_q[b] + DW'(1);
    end
  end
  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    if (sync[3]) state_d = HALTED;
    else if (state_q == PAUSED) begin
      state_d = press_q[0] ? RUNNING : PAUSED;
      en_d    = press_q[1] & ~press_q[0];
    end else if (state_q == RUNNING) begin
      state_d = press_q[0] ? PAUSED : RUNNING;
      en_d    = tick_q & ~press_q[0];
    end
  end
`ifdef STEP_COUNT_SAT_EN
  assign count_inc = &count_q ? count_q : count_q + COUNT_W'(1);
`else
  assign count_inc = count_q + COUNT_W'(1);
`endif
  always_ff @(posedge C_50Mhz or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      c1_prev_q <= 1'b0;
      tick_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      press_q   <= '0;
      state_q   <= PAUSED;
      step_en_q <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
      c1_prev_q <= sync[0];
      tick_q    <= sync[0] & ~c1_prev_q;
      acc_q     <= acc_q ^ flip;
      cnt_q     <= cnt_d;
      press_q   <= flip & ~acc_q;
      state_q   <= state_d;
      step_en_q <= en_d;
      running_q <= state_d == RUNNING;
      halted_q  <= state_d == HALTED;
      if (en_d) count_q <= count_inc;
    end
  end
  assign step_en    = step_en_q;
  assign running    = running_q;
  assign halted     = halted_q;
  assign step_count = count_q;
endmodule

// File: tb/tb_step_controller.sv
// tb_step_controller: random stimulus against an index-arithmetic reference model of step_controller.
module tb_step_controller;
  localparam int SYNC = 2, DEB = 4, CW = 4, MAXN = 4096;
  logic clk = 1'b0, rst = 1'b0, c1 = 1'b0, bm = 1'b0, bs = 1'b0, hl = 1'b0;
  logic step_en, running, halted;
  logic [CW-1:0] step_count;
  int errs = 0, checks = 0;
  bit [3:0] p [MAXN];
  bit [1:0] prs [MAXN];
  int n, st, cnt, last_flip [2];
  bit acc [2];
  bit m_en, g_c, g_m, g_s;
  int c1_left, m_left, s_left;

  step_controller #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC), .COUNT_W(CW)) dut (
    .C_50Mhz(clk), .rst(rst), .C_1Hz(c1), .btn_mode(bm), .btn_step(bs), .halt(hl),
    .step_en(step_en), .running(running), .halted(halted), .step_count(step_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  // synchronized level seen after edge t: the pin value sampled SYNC-1 edges earlier
  function automatic bit sv(int ch, int t);
    int k = t - SYNC + 1;
    return (k < 1) ? 1'b0 : p[k][ch];
  endfunction

  task automatic model_reset();
    foreach (p[i]) p[i] = '0;
    foreach (prs[i]) prs[i] = '0;
    n = 0; st = 0; cnt = 0; m_en = 0;
    for (int b = 0; b < 2; b++) begin acc[b] = 0; last_flip[b] = 0; end
  endtask

  task automatic model_step();
    bit tick, hlt, mp, sp;
    n++;
    for (int b = 0; b < 2; b++) begin
      bit ok;
      ok = (n - DEB >= last_flip[b]);
      for (int t = n - DEB; t < n; t++) if (sv(b + 1, t) == acc[b]) ok = 0;
      prs[n][b] = ok && !acc[b];
      if (ok) begin acc[b] = !acc[b]; last_flip[b] = n; end
    end
    mp   = prs[n-1][0];
    sp   = prs[n-1][1];
    tick = sv(0, n - 2) && !sv(0, n - 3);
    hlt  = sv(3, n - 1);
    m_en = 0;
    if (hlt) st = 2;
    else if (st == 0) begin
      if (mp) st = 1; else m_en = sp;
    end else if (st == 1) begin
      if (mp) st = 0; else m_en = tick;
    end
    if (m_en) begin
`ifdef STEP_COUNT_SAT_EN
      if (cnt != (1 << CW) - 1) cnt++;
`else
      cnt = (cnt + 1) % (1 << CW);
`endif
    end
  endtask

  task automatic cyc(input bit c, input bit m, input bit s, input bit h);
    c1 = c; bm = m; bs = s; hl = h;
    p[n+1] = {h, s, m, c};
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("step_en", step_en, m_en);
    chk("running", running, st == 1);
    chk("halted", halted, st == 2);
    chk("step_count", step_count, cnt);
  endtask

  task automatic rnd_cyc(input bit h);
    if (c1_left == 0) begin g_c = !g_c; c1_left = $urandom_range(2, 12); end
    if (m_left == 0) begin g_m = !g_m; m_left = g_m ? $urandom_range(1, 8) : $urandom_range(4, 40); end
    if (s_left == 0) begin g_s = !g_s; s_left = g_s ? $urandom_range(1, 8) : $urandom_range(2, 20); end
    c1_left--; m_left--; s_left--;
    cyc(g_c, g_m, g_s, h);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_step_en", step_en, 0);
    chk("rst_running", running, 0);
    chk("rst_halted", halted, 0);
    chk("rst_count", step_count, 0);
    bm = 0; bs = 0; hl = 0; g_m = 0; g_s = 0; m_left = 5; s_left = 5; c1_left = 3;
    repeat (hold) begin
      @(posedge clk);
      #1 c1 = !c1;
    end
    @(negedge clk);
    chk("rst_hold_en", step_en, 0);
    rst = 1'b0;
    g_c = c1;
    model_reset();
  endtask

  initial begin
    do_reset(3);
    repeat (6) cyc(0, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    repeat (5) begin
      repeat (10) cyc(1, 0, 0, 0);
      repeat (10) cyc(0, 0, 0, 0);
    end
    chk("run_count5", step_count, 5);
    chk("run_running", running, 1);
    repeat (1500) rnd_cyc(0);
    do_reset(7);
    for (int i = 0; i < 40; i++) cyc(i % 6 < 3, 0, 0, 0);
    chk("post_rst_count", step_count, 0);
    repeat (3) cyc(0, 0, 1, 0);
    repeat (6) cyc(0, 0, 0, 0);
    chk("glitch_count", step_count, 0);
    repeat (17) begin
      repeat (6) cyc(0, 0, 1, 0);
      repeat (6) cyc(0, 0, 0, 0);
    end
`ifdef STEP_COUNT_SAT_EN
    chk("count17", step_count, 15);
`else
    chk("count17", step_count, 1);
`endif
    repeat (300) rnd_cyc(0);
    repeat (20) rnd_cyc(1);
    repeat (300) rnd_cyc(0);
    chk("halt_latched", halted, 1);
    do_reset(4);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
